call_frame_stack: RTL and testbench

//   Parametrised call/return frame stack for the bytecode core. Replaces the fixed

---
 rtl/call_frame_stack.sv | 117 +++++++++++
 tb/tb_call_frame_stack.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_frame_stack.sv
// Call/return frame stack: {return PC, caller TOS} frames in a synchronous RAM,
// with tail-call replacement, sticky error flags and a valid-tagged return value.
module call_frame_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CALL_REQ,
    input  logic [ADDR_WIDTH-1:0] CALL_PC,
    input  logic [ADDR_WIDTH-1:0] CALL_TOS,
    input  logic                  RET_REQ,
    output logic                  READY,
    output logic                  RET_VALID,
    output logic [ADDR_WIDTH-1:0] RET_PC,
    output logic [ADDR_WIDTH-1:0] RET_TOS,
    input  logic                  RETVAL_WE,
    input  logic [DATA_WIDTH-1:0] RETVAL_IN,
    input  logic                  RETVAL_TAKE,
    output logic [DATA_WIDTH-1:0] RETVAL_OUT,
    output logic                  RETVAL_VALID,
    output logic [DEPTH_LOG2:0]   DEPTH,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  ERR_CLEAR
);
    // Handshake: a request is taken on a rising edge only when READY=1 at that
    // edge; requests presented while READY=0 are dropped, never queued.

    typedef enum logic {IDLE = 1'b0, POP_RD = 1'b1} state_t;

    localparam logic [DEPTH_LOG2:0] ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                    state, next_state;
    logic                      do_push, do_tail, do_pop, set_ov, set_un;
    logic [DEPTH_LOG2:0]       depth_m1;
    logic [DEPTH_LOG2-1:0]     top_addr, wr_addr;
    logic [2*ADDR_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];
    logic [2*ADDR_WIDTH-1:0]   rd_data;

    assign FULL     = (DEPTH == CAP);
    assign EMPTY    = (DEPTH == '0);
    assign depth_m1 = DEPTH - ONE;
    assign top_addr = depth_m1[DEPTH_LOG2-1:0];
    assign wr_addr  = do_tail ? top_addr : DEPTH[DEPTH_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        READY      = 1'b0;
        do_push    = 1'b0;
        do_tail    = 1'b0;
        do_pop     = 1'b0;
        set_ov     = 1'b0;
        set_un     = 1'b0;
        case (state)
            IDLE: begin
                READY = 1'b1;
                // A CALL+RET on an empty stack degrades to a plain CALL.
                if (CALL_REQ && RET_REQ && !EMPTY) begin
                    do_tail = 1'b1;
                end else if (CALL_REQ) begin
                    if (FULL) set_ov  = 1'b1;
                    else      do_push = 1'b1;
                end else if (RET_REQ) begin
                    if (EMPTY) begin
                        set_un = 1'b1;
                    end else begin
                        do_pop     = 1'b1;
                        next_state = POP_RD;
                    end
                end
            end
            POP_RD: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && (do_push || do_tail)) mem[wr_addr] <= {CALL_PC, CALL_TOS};
        if (!reset && do_pop)               rd_data      <= mem[top_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DEPTH        <= '0;
            RET_VALID    <= 1'b0;
            RET_PC       <= '0;
            RET_TOS      <= '0;
            RETVAL_OUT   <= '0;
            RETVAL_VALID <= 1'b0;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
            RET_VALID <= (state == POP_RD);
            if (state == POP_RD) {RET_PC, RET_TOS} <= rd_data;
            if (do_push)     DEPTH <= DEPTH + ONE;
            else if (do_pop) DEPTH <= depth_m1;
            // A fresh error in the clearing cycle keeps its flag set.
            OVERFLOW  <= set_ov | (OVERFLOW  & ~ERR_CLEAR);
            UNDERFLOW <= set_un | (UNDERFLOW & ~ERR_CLEAR);
            if (RETVAL_WE) begin
                RETVAL_OUT   <= RETVAL_IN;
                RETVAL_VALID <= 1'b1;
            end else if (RETVAL_TAKE) begin
                RETVAL_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_call_frame_stack.sv
// Directed bench for call_frame_stack: a queue-based stack model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_call_frame_stack;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        call_req = 1'b0, ret_req = 1'b0;
    logic [11:0] call_pc = '0, call_tos = '0;
    logic        retval_we = 1'b0, retval_take = 1'b0, err_clear = 1'b0;
    logic [7:0]  retval_in = '0;
    logic        ready, ret_valid, retval_valid, full, empty, overflow, underflow;
    logic [11:0] ret_pc, ret_tos;
    logic [7:0]  retval_out;
    logic [6:0]  depth;

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    call_frame_stack #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .DEPTH_LOG2(6)) dut (
        .clk(clk), .reset(reset),
        .CALL_REQ(call_req), .CALL_PC(call_pc), .CALL_TOS(call_tos), .RET_REQ(ret_req),
        .READY(ready), .RET_VALID(ret_valid), .RET_PC(ret_pc), .RET_TOS(ret_tos),
        .RETVAL_WE(retval_we), .RETVAL_IN(retval_in), .RETVAL_TAKE(retval_take),
        .RETVAL_OUT(retval_out), .RETVAL_VALID(retval_valid),
        .DEPTH(depth), .FULL(full), .EMPTY(empty),
        .OVERFLOW(overflow), .UNDERFLOW(underflow), .ERR_CLEAR(err_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack model: the frame stack is a queue; a pop in flight is one pending frame.
    logic [23:0] m_stack[$];
    logic [23:0] m_pending = '0;
    logic        m_busy = 1'b0, m_ret_valid = 1'b0, m_ov = 1'b0, m_un = 1'b0, m_rvv = 1'b0;
    logic [11:0] m_ret_pc = '0, m_ret_tos = '0;
    logic [7:0]  m_rv = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_stack.delete();
            m_busy = 0; m_ret_valid = 0; m_ret_pc = 0; m_ret_tos = 0;
            m_ov = 0; m_un = 0; m_rv = 0; m_rvv = 0;
        end else begin
            m_ret_valid = 0;
            if (err_clear) begin m_ov = 0; m_un = 0; end
            if (m_busy) begin
                {m_ret_pc, m_ret_tos} = m_pending;
                m_ret_valid = 1;
                m_busy = 0;
            end else if (call_req && ret_req && m_stack.size() > 0) begin
                m_stack[m_stack.size()-1] = {call_pc, call_tos};
            end else if (call_req) begin
                if (m_stack.size() < 64) m_stack.push_back({call_pc, call_tos});
                else                     m_ov = 1;
            end else if (ret_req) begin
                if (m_stack.size() > 0) begin
                    m_pending = m_stack.pop_back();
                    m_busy = 1;
                end else begin
                    m_un = 1;
                end
            end
            if (retval_we) begin m_rv = retval_in; m_rvv = 1; end
            else if (retval_take) m_rvv = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_ready",     32'(ready),        32'(!m_busy));
            chk("m_ret_valid", 32'(ret_valid),    32'(m_ret_valid));
            chk("m_ret_pc",    32'(ret_pc),       32'(m_ret_pc));
            chk("m_ret_tos",   32'(ret_tos),      32'(m_ret_tos));
            chk("m_depth",     32'(depth),        32'(m_stack.size()));
            chk("m_full",      32'(full),         32'(m_stack.size() == 64));
            chk("m_empty",     32'(empty),        32'(m_stack.size() == 0));
            chk("m_overflow",  32'(overflow),     32'(m_ov));
            chk("m_underflow", 32'(underflow),    32'(m_un));
            chk("m_retval",    32'(retval_out),   32'(m_rv));
            chk("m_retval_v",  32'(retval_valid), 32'(m_rvv));
        end
    end

    task automatic drive(input logic c, input logic [11:0] pc, input logic [11:0] tos,
                         input logic r, input logic we, input logic [7:0] din,
                         input logic take, input logic clr);
        call_req = c; call_pc = pc; call_tos = tos; ret_req = r;
        retval_we = we; retval_in = din; retval_take = take; err_clear = clr;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_call(input logic [11:0] pc, input logic [11:0] tos);
        drive(1, pc, tos, 0, 0, 0, 0, 0);
    endtask

    task automatic do_ret();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        nop();
        cmp_en = 1'b1;
        reset = 1'b0;
        chk("rst_depth", 32'(depth), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_flags", 32'({ret_valid, overflow, underflow, retval_valid}), 0);
        chk("rst_ret_pc", 32'(ret_pc), 0);

        // Simple call then return
        do_call(12'h123, 12'h045);
        chk("t1_depth1", 32'(depth), 1);
        do_ret();
        chk("t1_ready0", 32'(ready), 0);
        chk("t1_depth0", 32'(depth), 0);
        nop();
        chk("t1_valid", 32'(ret_valid), 1);
        chk("t1_pc", 32'(ret_pc), 32'h123);
        chk("t1_tos", 32'(ret_tos), 32'h045);
        nop();
        chk("t1_pulse", 32'(ret_valid), 0);
        chk("t1_hold", 32'(ret_pc), 32'h123);

        // Fill to capacity, overflow, drain in LIFO order
        for (int i = 0; i < 64; i++) do_call(12'(i), 12'h800 | 12'(i));
        chk("t2_full", 32'(full), 1);
        chk("t2_depth64", 32'(depth), 64);
        do_call(12'hFFF, 12'hFFF);
        chk("t2_overflow", 32'(overflow), 1);
        chk("t2_depth_held", 32'(depth), 64);
        for (int i = 0; i < 64; i++) begin
            do_ret();
            nop();
            chk("t2_pop_valid", 32'(ret_valid), 1);
            chk("t2_pop_pc", 32'(ret_pc), 32'(63 - i));
            chk("t2_pop_tos", 32'(ret_tos), 32'(12'h800 | 12'(63 - i)));
        end
        chk("t2_empty", 32'(empty), 1);

        // Underflow and flag clearing
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t3_ov_clear", 32'(overflow), 0);
        do_ret();
        chk("t3_underflow", 32'(underflow), 1);
        chk("t3_ready", 32'(ready), 1);
        nop();
        chk("t3_no_valid", 32'(ret_valid), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t3_cleared", 32'(underflow), 0);
        drive(0, 0, 0, 1, 0, 0, 0, 1);
        chk("t3_err_wins", 32'(underflow), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Tail call replaces the top frame
        do_call(12'h0AA, 12'h0BB);
        drive(1, 12'h0CC, 12'h0DD, 1, 0, 0, 0, 0);
        chk("t4_depth", 32'(depth), 1);
        nop();
        chk("t4_no_valid", 32'(ret_valid), 0);
        do_ret();
        nop();
        chk("t4_pc", 32'(ret_pc), 32'h0CC);
        chk("t4_tos", 32'(ret_tos), 32'h0DD);

        // CALL during POP_RD is dropped
        for (int i = 1; i <= 3; i++) do_call(12'h300 | 12'(i), 12'h400 | 12'(i));
        do_ret();
        chk("t5_ready0", 32'(ready), 0);
        do_call(12'h777, 12'h777);
        chk("t5_valid", 32'(ret_valid), 1);
        chk("t5_pc", 32'(ret_pc), 32'h303);
        chk("t5_depth", 32'(depth), 2);
        nop();
        chk("t5_depth_end", 32'(depth), 2);

        // Return-value register
        drive(0, 0, 0, 0, 1, 8'hAB, 0, 0);
        chk("t6_rv_ab", 32'({retval_valid, retval_out}), 32'h1AB);
        drive(0, 0, 0, 0, 1, 8'hCD, 1, 0);
        chk("t6_rv_cd", 32'({retval_valid, retval_out}), 32'h1CD);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t6_take", 32'(retval_valid), 0);
        do_ret();
        drive(0, 0, 0, 0, 1, 8'h5E, 0, 0);
        chk("t6_we_in_pop", 32'({retval_valid, retval_out}), 32'h15E);

        // Reset while in POP_RD
        do_ret();
        chk("t6_popping", 32'(ready), 0);
        reset = 1'b1;
        nop();
        reset = 1'b0;
        chk("t6_rst_valid", 32'(ret_valid), 0);
        chk("t6_rst_depth", 32'(depth), 0);
        chk("t6_rst_ready", 32'(ready), 1);
        nop();
        chk("t6_rst_no_pulse", 32'(ret_valid), 0);

        // CALL+RET on an empty stack acts as a plain CALL
        drive(1, 12'h5A5, 12'h0A5, 1, 0, 0, 0, 0);
        chk("t7_depth", 32'(depth), 1);
        chk("t7_no_underflow", 32'(underflow), 0);
        do_ret();
        nop();
        chk("t7_pc", 32'(ret_pc), 32'h5A5);
        nop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
